mem_access_stage: RTL

- Memory stage of the 5-stage pipeline.
- Consumes the execute stage's registered outputs: ALU result/address, store data, destination register, memWr/regWr/m2Reg.
- Performs the data-memory access over a req/ack handshake and stalls upstream while the access is outstanding.
- Registers the writeback bundle; the registered M_W_data also feeds the execute-stage forwarding muxes.

---
 rtl/mem_access_stage_if.sv | 30 +++
 rtl/mem_access_stage.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory request/ack bus between the MEM stage (master) and data memory (slave).
// Request fields are held stable from issue until the one-cycle ack pulse.
interface mem_access_stage_if #(
  parameter int ADDR_W = 12
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ack
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: data-memory access over req/ack; DMEM_TIMEOUT_EN adds an abort timer + sticky memErr.
// Latency: 1 cycle for non-memory ops, 1 + N cycles for loads/stores (N WAIT cycles up to and incl. ack).
// Backpressure: combinational memStall holds upstream from request issue until the ack (or abort) cycle.
module mem_access_stage #(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 15
) (
  input  logic               clock,
  input  logic               aclr,
  input  logic [31:0]        alu_resultIn,
  input  logic [31:0]        RData2In,
  input  logic [4:0]         RdIn,
  input  logic               memWrIn,
  input  logic               m2RegIn,
  input  logic               regWrIn,
  mem_access_stage_if.master dmem,
  output logic               memStall,
  output logic [31:0]        M_W_data,
  output logic [4:0]         RdMemOut,
  output logic               regWrMem,
  output logic               memErr
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state_q;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       wb_data_q, wb_data_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic              wb_we_q, wb_we_d;

  logic              acc;
  logic              abort;
  logic              done;
  logic [31:0]       rdata_eff;
  logic              unused_timeout;

  assign acc            = memWrIn | m2RegIn;
  assign unused_timeout = (TIMEOUT > 0);

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // Counter holds the number of ack-less WAIT cycles already elapsed.
  assign abort = (state_q == S_WAIT) && !dmem.dmem_ack &&
                 (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE) begin
        cnt_q <= '0;
      end else if (!dmem.dmem_ack) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (abort) begin
        err_q <= 1'b1;
      end
    end
  end

  assign memErr = err_q;
`else
  assign abort  = 1'b0;
  assign memErr = 1'b0;
`endif

  assign done      = (state_q == S_WAIT) && (dmem.dmem_ack || abort);
  assign rdata_eff = dmem.dmem_ack ? dmem.dmem_rdata : 32'h0;
  assign memStall  = (state_q == S_IDLE) ? acc : !done;

  // A store with m2RegIn also set is treated as a plain store.
  always_comb begin
    wb_data_d = alu_resultIn;
    wb_rd_d   = RdIn;
    wb_we_d   = 1'b0;
    if (state_q == S_IDLE) begin
      if (!acc) begin
        wb_we_d = regWrIn;
      end
    end else if (done) begin
      wb_we_d = regWrIn & ~memWrIn;
      if (m2RegIn && !memWrIn) begin
        wb_data_d = rdata_eff;
      end
    end
  end

  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      wb_we_q   <= 1'b0;
    end else begin
      wb_data_q <= wb_data_d;
      wb_rd_q   <= wb_rd_d;
      wb_we_q   <= wb_we_d;
      if (state_q == S_IDLE) begin
        if (acc) begin
          req_q   <= 1'b1;
          we_q    <= memWrIn;
          addr_q  <= alu_resultIn[ADDR_W-1:0];
          wdata_q <= RData2In;
          state_q <= S_WAIT;
        end
      end else if (done) begin
        req_q   <= 1'b0;
        state_q <= S_IDLE;
      end
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign M_W_data        = wb_data_q;
  assign RdMemOut        = wb_rd_q;
  assign regWrMem        = wb_we_q;

endmodule
